inflation_frame_ctrl: RTL

- Frame-level sequencer for the map-inflation accelerator.
- Per host command, it optionally triggers a weight reload, gates the input AXI-Stream into the datapath for exactly one frame's worth of row beats, and counts PE output rows.
- It generates TLAST on the last output row, then pulses done.
- It sits between the host/DMA control registers and the weight_loader / data_accumulator / output FIFO chain.

---
 rtl/inflation_frame_ctrl_pkg.sv | 27 ++
 rtl/inflation_frame_ctrl_frame_row_counter.sv | 62 ++++++
 rtl/inflation_frame_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/inflation_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inflation_frame_ctrl_pkg
// Purpose  : Shared state encoding and sizing helpers for the frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package inflation_frame_ctrl_pkg;

    localparam int DIM_WIDTH_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Input-stream beats needed to carry one row of pixels.
    function automatic int calc_beats_per_row(input int kernel_size,
                                              input int data_width,
                                              input int bus_width);
        return (kernel_size * data_width + bus_width - 1) / bus_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inflation_frame_ctrl_frame_row_counter.sv
`default_nettype none
// ============================================================================
// Module   : frame_row_counter
// Purpose  : Beat-to-row counter with clear, saturation at limit and flags.
// Revision : 1.0 - initial release
// ============================================================================
module frame_row_counter #(
    parameter int BEATS = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             full,
    output logic             last
);

    logic w_step;
    logic w_wrap;

    assign w_step = en & ~full;

    generate
        if (BEATS > 1) begin : g_multi_beat
            localparam int BW = $clog2(BEATS);
            logic [BW-1:0] r_beat;

            assign w_wrap = w_step & (r_beat == BW'(BEATS - 1));

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_beat <= '0;
                end else if (clr) begin
                    r_beat <= '0;
                end else if (w_step) begin
                    r_beat <= w_wrap ? '0 : r_beat + 1'b1;
                end
            end
        end else begin : g_single_beat
            assign w_wrap = w_step;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (w_wrap) begin
            count <= count + 1'b1;
        end
    end

    assign full = (count == limit);
    // High on the beat that completes the final row of the frame.
    assign last = w_wrap & (count == limit - 1'b1);

endmodule
`default_nettype wire

// File: rtl/inflation_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : inflation_frame_ctrl
// Purpose  : Frame sequencer: weight reload, input gating, output row count.
// Revision : 1.0 - initial release
// ============================================================================
module inflation_frame_ctrl
    import inflation_frame_ctrl_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int BUS_WIDTH   = 32,
    parameter int DIM_WIDTH   = DIM_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cfg_start,
    input  logic [DIM_WIDTH-1:0] cfg_rows,
    input  logic                 cfg_load_weights,
    input  logic                 cfg_abort,
    output logic                 busy,
    output logic                 done,
    output logic                 err_overflow,
    output logic                 wl_start,
    input  logic                 wl_done,
    input  logic                 in_tvalid,
    input  logic                 in_tready,
    output logic                 in_gate,
    input  logic                 out_tvalid,
    input  logic                 out_tready,
    output logic                 out_tlast,
    output logic [DIM_WIDTH-1:0] rows_in_cnt,
    output logic [DIM_WIDTH-1:0] rows_out_cnt
);

    localparam int BEATS_PER_ROW = calc_beats_per_row(KERNEL_SIZE, DATA_WIDTH, BUS_WIDTH);

    state_t               r_state;
    logic [DIM_WIDTH-1:0] r_rows;
    logic                 r_done;
    logic                 r_wl_start;
    logic                 r_err;

    logic w_start_acc, w_abort, w_clr, w_streaming;
    logic w_in_hs, w_out_hs;
    logic w_in_full, w_in_last, w_out_full, w_out_last;
    logic w_ovf_set;

    assign w_start_acc = (r_state == ST_IDLE) & cfg_start;
    assign w_abort     = cfg_abort & (r_state != ST_IDLE);
    assign w_clr       = w_start_acc | w_abort;
    assign w_streaming = (r_state == ST_STREAM) | (r_state == ST_DRAIN);
    assign w_in_hs     = in_gate & in_tvalid & in_tready;
    assign w_out_hs    = out_tvalid & out_tready;

    frame_row_counter #(.BEATS(BEATS_PER_ROW), .WIDTH(DIM_WIDTH)) u_in_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (w_clr),
        .en    (w_in_hs & (r_state == ST_STREAM)),
        .limit (r_rows),
        .count (rows_in_cnt),
        .full  (w_in_full),
        .last  (w_in_last)
    );

    frame_row_counter #(.BEATS(1), .WIDTH(DIM_WIDTH)) u_out_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (w_clr),
        .en    (w_out_hs & w_streaming),
        .limit (r_rows),
        .count (rows_out_cnt),
        .full  (w_out_full),
        .last  (w_out_last)
    );

    // Output beats with nowhere to go, or output finishing before input did.
    assign w_ovf_set = (w_out_hs & ((r_state == ST_IDLE) | (r_state == ST_LOAD_W) |
                                    (r_state == ST_DONE) | (w_streaming & w_out_full)))
                     | ((r_state == ST_STREAM) & w_out_last & ~w_in_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_rows     <= '0;
            r_done     <= 1'b0;
            r_wl_start <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_wl_start <= 1'b0;
            if (w_ovf_set) begin
                r_err <= 1'b1;
            end
            if (w_abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cfg_start) begin
                            r_rows <= cfg_rows;
                            r_err  <= 1'b0;
                            if (cfg_rows == '0) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else if (cfg_load_weights) begin
                                r_state    <= ST_LOAD_W;
                                r_wl_start <= 1'b1;
                            end else begin
                                r_state <= ST_STREAM;
                            end
                        end
                    end
                    ST_LOAD_W: begin
                        if (wl_done) begin
                            r_state <= ST_STREAM;
                        end
                    end
                    ST_STREAM: begin
                        if (w_in_last) begin
                            if (w_out_full | w_out_last) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (w_out_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign wl_start     = r_wl_start;
    assign err_overflow = r_err;
    assign in_gate      = (r_state == ST_LOAD_W) | ((r_state == ST_STREAM) & ~w_in_full);
    assign out_tlast    = out_tvalid & w_streaming & (rows_out_cnt == r_rows - 1'b1);

endmodule
`default_nettype wire
